pieo_op_sched: RTL and testbench

Operation scheduler in front of the Shale PIEO sorted list. Accepts enqueue requests (cells to be held for a forwarding bucket) and dequeue requests (extract the eligible cell for the current bucket bitmap), serializes them into single PIEO operations under a start/done handshake, and tracks list occupancy. Dequeue is prioritized, with a starvation guard for enqueue. The block answers dequeues on an empty list locally.

---
 rtl/pieo_datatypes.sv | 32 +++
 rtl/pieo_op_sched_occ.sv | 38 +++
 rtl/pieo_op_sched.sv | 177 +++++++++++++++++
 tb/tb_pieo_op_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pieo_datatypes.sv
// Shared PIEO types: list geometry, sublist element layout, scheduler command.
// Pure declarations; no timing or backpressure of its own.
package pieo_datatypes;

    localparam int LIST_SIZE   = 9;
    localparam int TIME_LOG    = 6;
    localparam int NULL_BUCKET = 5;

    localparam int ID_W   = 8;
    localparam int RANK_W = 6;
    localparam int ST_W   = $clog2(TIME_LOG);

    // send_time indexes a bit of the bucket bitmap; NULL_BUCKET marks an empty entry
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RANK_W-1:0] rank;
        logic [ST_W-1:0]   send_time;
    } SublistElement;

    typedef enum logic {
        ENQ = 1'b0,
        DEQ = 1'b1
    } pieo_op_t;

    // tmap is the bucket bitmap handed to the PIEO for a dequeue
    typedef struct packed {
        pieo_op_t            op;
        SublistElement       elem;
        logic [TIME_LOG-1:0] tmap;
    } PieoCmd;

endpackage

// File: rtl/pieo_op_sched_occ.sv
// Saturating list-occupancy counter with full/empty flags.
// Latency: count updates on the edge after inc/dec; flags and err are combinational.
// Backpressure: none; an over/underflow attempt is refused and flagged on err.
module pieo_occ_counter
    import pieo_datatypes::*;
#(
    parameter int DEPTH = LIST_SIZE,
    parameter int W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty,
    output logic         err
);

    localparam logic [W-1:0] MAX = W'(DEPTH);

    always_comb begin
        full  = (count == MAX);
        empty = (count == '0);
        err   = (inc && !dec && full) || (dec && !inc && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pieo_op_sched.sv
// Serializes enqueue/dequeue requests into single PIEO operations; tracks occupancy.
// Latency: handshake T -> pieo_start T+1; pieo_done D -> resp D+1; empty-list dequeue answered at T+1.
// Backpressure: both readies low outside IDLE or while pieo_ready is low; dequeue wins unless enqueue is starved.
module pieo_op_sched #(
    parameter int LIST_SIZE    = pieo_datatypes::LIST_SIZE,
    parameter int TIME_LOG     = pieo_datatypes::TIME_LOG,
    parameter int NULL_BUCKET  = pieo_datatypes::NULL_BUCKET,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  pieo_datatypes::SublistElement    enq_elem,

    input  logic                             deq_valid,
    output logic                             deq_ready,
    input  logic [TIME_LOG-1:0]              deq_time,

    output logic                             resp_valid,
    output logic                             resp_hit,
    output pieo_datatypes::SublistElement    resp_elem,

    output logic                             pieo_start,
    output logic                             pieo_op,
    output pieo_datatypes::SublistElement    pieo_elem,
    output logic [TIME_LOG-1:0]              pieo_time,

    input  logic                             pieo_ready,
    input  logic                             pieo_done,
    input  logic                             pieo_deq_hit,
    input  pieo_datatypes::SublistElement    pieo_deq_elem,

    output logic [$clog2(LIST_SIZE+1)-1:0]   occupancy,
    output logic                             full,
    output logic                             empty,
    output logic                             err
);

    import pieo_datatypes::PieoCmd;
    import pieo_datatypes::ENQ;
    import pieo_datatypes::DEQ;
    import pieo_datatypes::ST_W;

    localparam int OCC_W = $clog2(LIST_SIZE + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [ST_W-1:0] NULL_ST    = ST_W'(NULL_BUCKET);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    PieoCmd            cmd;
    logic [SC_W-1:0]   starve_cnt;

    logic                enq_elig;
    logic                starved;
    logic                arb_ok;
    logic                enq_null;
    logic                done_ok;
    logic                occ_inc;
    logic                occ_dec;
    logic                occ_err;
    logic [TIME_LOG-1:0] deq_tmap;

    always_comb begin
        enq_elig  = enq_valid && !full;
        starved   = (starve_cnt == STARVE_MAX);
        arb_ok    = (state == S_IDLE) && pieo_ready;
        // readies already fold in valid, so a high ready is a completed handshake
        enq_ready = arb_ok && enq_elig && (!deq_valid || starved);
        deq_ready = arb_ok && deq_valid && !(starved && enq_elig);
        enq_null  = (enq_elem.send_time == NULL_ST);
        deq_tmap  = deq_time;
        deq_tmap[NULL_BUCKET] = 1'b0;
        done_ok   = (state == S_WAIT) && pieo_done;
        occ_inc   = done_ok && (cmd.op == ENQ);
        occ_dec   = done_ok && (cmd.op == DEQ) && pieo_deq_hit;
    end

    assign pieo_op   = cmd.op;
    assign pieo_elem = cmd.elem;
    assign pieo_time = cmd.tmap;

    pieo_occ_counter #(
        .DEPTH (LIST_SIZE),
        .W     (OCC_W)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (occ_inc),
        .dec   (occ_dec),
        .count (occupancy),
        .full  (full),
        .empty (empty),
        .err   (occ_err)
    );

    // Starvation guard: counts dequeue wins that passed over a waiting enqueue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!enq_elig || enq_ready) begin
            starve_cnt <= '0;
        end else if (deq_ready && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (occ_err
                     || (pieo_done && (state != S_WAIT))
                     || (enq_ready && enq_null)
                     || (deq_ready && deq_time[NULL_BUCKET])) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd        <= '0;
            pieo_start <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_elem  <= '0;
        end else begin
            pieo_start <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_elem  <= '0;
            case (state)
                S_IDLE: begin
                    if (enq_ready && !enq_null) begin
                        cmd        <= '{op: ENQ, elem: enq_elem, tmap: '0};
                        pieo_start <= 1'b1;
                        state      <= S_ISSUE;
                    end else if (deq_ready) begin
                        if (empty) begin
                            // nothing to extract: answer a miss locally
                            resp_valid <= 1'b1;
                        end else begin
                            cmd        <= '{op: DEQ, elem: '0, tmap: deq_tmap};
                            pieo_start <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pieo_done) begin
                        state <= S_IDLE;
                        if (cmd.op == DEQ) begin
                            resp_valid <= 1'b1;
                            resp_hit   <= pieo_deq_hit;
                            resp_elem  <= pieo_deq_elem;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pieo_op_sched.sv
// Bench for pieo_op_sched: in-bench PIEO responder, command/response scoreboards,
// a transaction table and hand-written arbitration, full-list and reset sequences.
module tb_pieo_op_sched;
    import pieo_datatypes::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                enq_valid, enq_ready;
    SublistElement       enq_elem;
    logic                deq_valid, deq_ready;
    logic [TIME_LOG-1:0] deq_time;
    logic                resp_valid, resp_hit;
    SublistElement       resp_elem;
    logic                pieo_start, pieo_op;
    SublistElement       pieo_elem;
    logic [TIME_LOG-1:0] pieo_time;
    logic                pieo_ready, pieo_done, pieo_deq_hit;
    SublistElement       pieo_deq_elem;
    logic [3:0]          occupancy;
    logic                full, empty, err;

    pieo_op_sched dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_time(deq_time),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_elem(resp_elem),
        .pieo_start(pieo_start), .pieo_op(pieo_op), .pieo_elem(pieo_elem), .pieo_time(pieo_time),
        .pieo_ready(pieo_ready), .pieo_done(pieo_done), .pieo_deq_hit(pieo_deq_hit),
        .pieo_deq_elem(pieo_deq_elem),
        .occupancy(occupancy), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic op; SublistElement elem; logic [TIME_LOG-1:0] tmap; int cyc; } cmd_exp_t;
    typedef struct { logic hit; SublistElement elem; int cyc; } resp_exp_t;
    typedef struct { logic op; int occ; } grant_t;
    typedef struct {
        logic is_deq; SublistElement elem; logic [TIME_LOG-1:0] tmap;
        logic hit; SublistElement relem; int delay;
        int exp_starts; int exp_occ; logic exp_err;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc_n = 0, done_cyc = 0, starts = 0, occ_m = 0;
    int done_delay = 1, pend_cnt = 0;
    bit pend = 0, pend_op = 0, auto_pieo = 1, stray_done = 0, last_hs = 0;
    logic          next_hit = 1'b0;
    SublistElement next_elem = '0;
    cmd_exp_t  cmd_q[$];
    resp_exp_t resp_q[$];
    grant_t    grant_q[$];
    vec_t      vecs[8];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic SublistElement mk(input int id, input int rank, input int st);
        SublistElement r;
        r.id = 8'(id); r.rank = 6'(rank); r.send_time = 3'(st);
        return r;
    endfunction

    // One clock: log handshakes, advance the edge, then play the PIEO and check outputs.
    task automatic cyc();
        bit eh, dh;
        logic [TIME_LOG-1:0] nmask;
        cmd_exp_t  c;
        resp_exp_t r;
        #1;
        eh = enq_valid && enq_ready;
        dh = deq_valid && deq_ready;
        last_hs = eh || dh;
        nmask = '1;
        nmask[NULL_BUCKET] = 1'b0;
        if (eh) begin
            grant_q.push_back('{op: 1'b0, occ: int'(occupancy)});
            if (enq_elem.send_time != 3'(NULL_BUCKET))
                cmd_q.push_back('{op: 1'b0, elem: enq_elem, tmap: '0, cyc: cyc_n + 1});
        end
        if (dh) begin
            grant_q.push_back('{op: 1'b1, occ: int'(occupancy)});
            if (occ_m == 0) begin
                resp_q.push_back('{hit: 1'b0, elem: '0, cyc: cyc_n + 1});
            end else begin
                cmd_q.push_back('{op: 1'b1, elem: '0, tmap: deq_time & nmask, cyc: cyc_n + 1});
                resp_q.push_back('{hit: next_hit, elem: next_elem, cyc: -1});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        pieo_done = 1'b0; pieo_deq_hit = 1'b0; pieo_deq_elem = '0;
        if (pend) begin
            if (pend_cnt > 1) pend_cnt--;
            else begin
                pend = 0; pieo_done = 1'b1; done_cyc = cyc_n;
                if (pend_op) begin
                    pieo_deq_hit = next_hit; pieo_deq_elem = next_elem;
                    if (next_hit) occ_m--;
                end else occ_m++;
            end
        end
        if (stray_done) begin stray_done = 0; pieo_done = 1'b1; end
        if (pieo_start) begin
            starts++;
            if (cmd_q.size() == 0) chk("start_unexpected", 1, 0);
            else begin
                c = cmd_q.pop_front();
                chk("start_cycle", cyc_n, c.cyc);
                chk("start_op", pieo_op, c.op);
                if (c.op) chk("start_time", pieo_time, c.tmap);
                else      chk("start_elem", pieo_elem, c.elem);
            end
            if (auto_pieo) begin pend = 1; pend_cnt = done_delay; pend_op = pieo_op; end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                r = resp_q.pop_front();
                chk("resp_cycle", cyc_n, (r.cyc < 0) ? done_cyc + 1 : r.cyc);
                chk("resp_hit", resp_hit, r.hit);
                chk("resp_elem", resp_elem, r.elem);
            end
        end
    endtask

    task automatic clear_model();
        cmd_q.delete(); resp_q.delete(); grant_q.delete();
        pend = 0; stray_done = 0; occ_m = 0; last_hs = 0;
        enq_valid = 0; deq_valid = 0; enq_elem = '0; deq_time = '0;
        pieo_done = 0; pieo_deq_hit = 0; pieo_deq_elem = '0; pieo_ready = 1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_model();
        auto_pieo = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int s0;
        s0 = starts;
        next_hit = v.hit; next_elem = v.relem; done_delay = v.delay;
        enq_elem = v.elem; deq_time = v.tmap;
        if (v.is_deq) deq_valid = 1; else enq_valid = 1;
        last_hs = 0;
        for (int i = 0; i < 20 && !last_hs; i++) cyc();
        chk($sformatf("v%0d_handshake", idx), last_hs, 1);
        enq_valid = 0; deq_valid = 0;
        repeat (8) cyc();
        chk($sformatf("v%0d_starts", idx), starts - s0, v.exp_starts);
        chk($sformatf("v%0d_occ", idx), occupancy, v.exp_occ);
        chk($sformatf("v%0d_empty", idx), empty, v.exp_occ == 0);
        chk($sformatf("v%0d_err", idx), err, v.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int held;
        vec_t v;
        rst = 1'b0;
        apply_reset();
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_start", pieo_start, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_pieo_time", pieo_time, 0);

        //        is_deq elem        tmap       hit  relem       dly starts occ err
        vecs[0] = '{1'b0, mk(1,3,2), 6'b000000, 1'b0, mk(0,0,0), 3, 1, 1, 1'b0};
        vecs[1] = '{1'b0, mk(2,5,0), 6'b000000, 1'b0, mk(0,0,0), 1, 1, 2, 1'b0};
        vecs[2] = '{1'b1, mk(0,0,0), 6'b000100, 1'b1, mk(1,3,2), 1, 1, 1, 1'b0};
        vecs[3] = '{1'b1, mk(0,0,0), 6'b000010, 1'b0, mk(0,0,0), 1, 1, 1, 1'b0};
        vecs[4] = '{1'b1, mk(0,0,0), 6'b000001, 1'b1, mk(2,5,0), 2, 1, 0, 1'b0};
        vecs[5] = '{1'b1, mk(0,0,0), 6'b000100, 1'b0, mk(0,0,0), 1, 0, 0, 1'b0};
        vecs[6] = '{1'b0, mk(3,1,5), 6'b000000, 1'b0, mk(0,0,0), 1, 0, 0, 1'b1};
        vecs[7] = '{1'b0, mk(4,2,1), 6'b000000, 1'b0, mk(0,0,0), 1, 1, 1, 1'b1};
        for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

        // dequeue bitmap with the null bucket bit set: forwarded with that bit cleared, err raised
        apply_reset();
        v = '{1'b0, mk(5,1,3), 6'b000000, 1'b0, mk(0,0,0), 1, 1, 1, 1'b0};
        do_txn(20, v);
        v = '{1'b1, mk(0,0,0), 6'b101000, 1'b1, mk(5,1,3), 1, 1, 0, 1'b1};
        do_txn(21, v);

        // both requesters saturated: four dequeues then one enqueue, repeating
        apply_reset();
        next_hit = 0; next_elem = '0; done_delay = 1;
        enq_elem = mk(7,2,1); deq_time = 6'b000010;
        enq_valid = 1; deq_valid = 1;
        for (int i = 0; i < 300 && grant_q.size() < 10; i++) cyc();
        enq_valid = 0; deq_valid = 0;
        chk("starve_grants", grant_q.size(), 10);
        for (int i = 0; i < 10 && i < grant_q.size(); i++)
            chk($sformatf("starve_g%0d_op", i), grant_q[i].op, (i % 5 == 4) ? 0 : 1);
        repeat (10) cyc();

        // fill to capacity, hold an enqueue, free one slot with a dequeue hit
        apply_reset();
        done_delay = 1; enq_elem = mk(9,4,1); enq_valid = 1;
        for (int i = 0; i < 200 && !full; i++) cyc();
        chk("full_flag", full, 1);
        chk("full_occ", occupancy, 9);
        held = 0;
        repeat (4) begin cyc(); if (last_hs) held++; end
        chk("full_enq_held", held, 0);
        chk("full_grants", grant_q.size(), 9);
        deq_valid = 1; deq_time = 6'b000010; next_hit = 1; next_elem = mk(9,4,1);
        for (int i = 0; i < 50 && grant_q.size() < 11; i++) begin
            cyc();
            if (grant_q.size() >= 10) deq_valid = 0;
        end
        enq_valid = 0;
        chk("full_after_grants", grant_q.size(), 11);
        if (grant_q.size() >= 11) begin
            chk("full_g9_op", grant_q[9].op, 1);
            chk("full_g10_op", grant_q[10].op, 0);
            chk("full_g10_occ", grant_q[10].occ, 8);
        end
        repeat (8) cyc();
        chk("full_final_occ", occupancy, 9);
        chk("full_final_full", full, 1);

        // reset while waiting on the PIEO, then a stray done
        apply_reset();
        auto_pieo = 0; done_delay = 1;
        enq_elem = mk(6,1,2); enq_valid = 1;
        last_hs = 0;
        for (int i = 0; i < 20 && !last_hs; i++) cyc();
        enq_valid = 0;
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_start", pieo_start, 0);
        chk("abort_elem", pieo_elem, 0);
        chk("abort_occ", occupancy, 0);
        chk("abort_empty", empty, 1);
        chk("abort_err", err, 0);
        chk("abort_resp_valid", resp_valid, 0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        auto_pieo = 1;
        stray_done = 1;
        cyc();
        cyc();
        chk("stray_done_err", err, 1);

        chk("sb_drain", resp_q.size() + cmd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
